fifo_stream_reader: RTL and testbench
=====================================

// Module: fifo_stream_reader
// PURPOSE
//   Read-side controller for the synchronous FIFO: drains the FIFO's r_en/data_out/empty port.
//   Presents the words as a valid/ready stream with packet framing (m_last every PKT_LEN words).
//   A 2-entry output buffer absorbs the FIFO's 1-cycle read latency.
//   Sustains 1 word/cycle with no loss or duplication under arbitrary backpressure.
// PARAMETERS
//   D_WIDTH  8   data width, equal to the FIFO data width
//   PKT_LEN  4   words per packet; m_last marks word PKT_LEN-1 of each packet; legal values >=1
//   CNT_W    16  width of the delivered-word counter rd_count
// PORTS
//   clk         in   1        single clock, rising edge
//   rst         in   1        asynchronous, active-high reset
//   enable      in   1        permission to issue new FIFO reads
//   fifo_empty  in   1        FIFO empty flag
//   fifo_data   in   D_WIDTH  FIFO data_out; valid the cycle after a read
//   fifo_r_en   out  1        FIFO read enable (combinational)
//   m_valid     out  1        stream word valid
//   m_data      out  D_WIDTH  stream word
//   m_last      out  1        last word of packet
//   m_ready     in   1        stream sink ready
//   rd_count    out  CNT_W    words handed off (m_valid & m_ready), wraps modulo 2^CNT_W
//   busy        out  1        buffer non-empty or a read in flight
// BEHAVIOUR
//   - Reset (async assert, sync release):
//     - m_valid=0, m_data=0, m_last=0, rd_count=0, busy=0, fifo_r_en=0.
//     - Buffer, in-flight flag and packet counter are cleared.
//     - A word in flight at reset is discarded.
//   - FIFO timing: r_en high in cycle N -> fifo_data valid in cycle N+1 -> written to buffer at the end of N+1.
//   - pop = m_valid & m_ready. occ = buffer entries (0..2). infl = read issued last cycle.
//   - fifo_r_en = !rst & enable & !fifo_empty & (occ + infl - pop < 2).
//     - occ + infl never exceeds 2.
//     - The buffer never overflows.
//   - Latency: first word appears on m_valid 2 cycles after its fifo_r_en, i.e. cycle N+2.
//   - Throughput: with m_ready=1 and the FIFO non-empty, fifo_r_en and pop are both high every cycle.
//   - Ordering: strict FIFO order through the buffer.
//     - Simultaneous write (infl) and pop in the same cycle is legal; occ is unchanged.
//   - Stream rules:
//     - Once m_valid=1, m_data and m_last are held stable until pop.
//     - m_valid never drops without pop.
//   - Packet counter pk (0..PKT_LEN-1):
//     - m_last = (pk == PKT_LEN-1) while m_valid.
//     - pk increments on pop and wraps to 0 after PKT_LEN-1.
//     - PKT_LEN=1 -> m_last=1 on every word.
//   - rd_count increments by 1 on each pop and wraps from 2^CNT_W-1 to 0.
//   - enable=0: no new reads; in-flight and buffered words are still delivered.
//     - enable takes effect combinationally in the same cycle.
//   - fifo_empty=1: no reads. The block never reads an empty FIFO.
//   - busy = (occ != 0) | infl.
//   - No FSM beyond occ/infl/pk; every register is a flop on clk with async rst.
// TESTING
//   1. rst=1, enable=1, fifo_empty=0 -> fifo_r_en=0, m_valid=0, rd_count=0, busy=0 throughout reset.
//   2. FIFO holds one word 0xA5, m_ready=1 -> fifo_r_en high 1 cycle (N).
//      m_valid=1 only in N+2 with m_data=0xA5 and m_last=0; then rd_count=1 and busy=0.
//   3. 30 random words, m_ready=1, PKT_LEN=4 -> 30 consecutive valid cycles in write order.
//      m_last on words 4,8,...,28; rd_count=30.
//   4. 30 words, m_ready alternating 1/0 -> all 30 words in order with no loss or duplication.
//      m_data/m_last stable while m_valid & !m_ready; occ+infl <= 2 every cycle.
//   5. enable dropped mid-stream, m_ready=1 -> fifo_r_en=0 from that cycle; <=2 further words delivered.
//      busy falls to 0; re-enable resumes with the next FIFO word.
//   6. rst pulsed mid-stream while m_valid=1 -> outputs clear before the next edge.
//      After release, rd_count restarts at 0 and the first new word has pk=0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side controller for a synchronous FIFO: turns the r_en/data_out/empty port into a
// framed valid/ready stream, using a 2-entry buffer to hide the FIFO's 1-cycle read latency.
module fifo_stream_reader #(
    parameter int D_WIDTH = 8,
    parameter int PKT_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               fifo_empty,
    input  logic [D_WIDTH-1:0] fifo_data,
    output logic               fifo_r_en,
    output logic               m_valid,
    output logic [D_WIDTH-1:0] m_data,
    output logic               m_last,
    input  logic               m_ready,
    output logic [CNT_W-1:0]   rd_count,
    output logic               busy
);

    localparam int PK_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PK_W-1:0] PK_MAX = PK_W'(PKT_LEN - 1);

    logic [1:0]         occ_q, occ_d;
    logic               infl_q, infl_d;
    logic [PK_W-1:0]    pk_q, pk_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [D_WIDTH-1:0] buf_q [2];
    logic [D_WIDTH-1:0] buf_d [2];
    logic               pop;
    logic [1:0]         wr_idx;
    logic [2:0]         level;

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf_q[0];
    assign m_last   = m_valid & (pk_q == PK_MAX);
    assign pop      = m_valid & m_ready;
    assign busy     = m_valid | infl_q;
    assign rd_count = cnt_q;

    // Occupancy after this cycle's arrival and departure; a new read is only safe below 2.
    assign level     = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
    assign fifo_r_en = !rst & enable & !fifo_empty & (level < 3'd2);

    always_comb begin
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        if (pop) begin
            buf_d[0] = buf_q[1];
        end
        // The arriving word lands behind whatever is still buffered after the shift.
        wr_idx = occ_q - {1'b0, pop};
        if (infl_q) begin
            buf_d[wr_idx[0]] = fifo_data;
        end
        occ_d  = occ_q + {1'b0, infl_q} - {1'b0, pop};
        infl_d = fifo_r_en;
        pk_d   = pk_q;
        if (pop) begin
            pk_d = (pk_q == PK_MAX) ? '0 : pk_q + PK_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= 2'd0;
            infl_q <= 1'b0;
            pk_q   <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            occ_q  <= occ_d;
            infl_q <= infl_d;
            pk_q   <= pk_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural FIFO feeds the reader and a
// negedge monitor checks order, framing, stream stability and outstanding-read bounds.
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic       m_ready = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_r_en, m_valid, m_last, busy;
    logic [7:0] m_data;
    logic [15:0] rd_count;
    logic       u1_fifo_r_en, u1_m_valid, u1_m_last, u1_busy;
    logic [7:0] u1_m_data;
    logic [3:0] u1_rd_count;

    logic [7:0] mem [0:255];
    int wp = 0, rp = 0, rd_issued = 0;
    int popped = 0, exp_idx = 0, tb_pk = 0, last_cnt = 0;
    logic hold_prev = 1'b0, prev_last = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int tests_run = 0, tests_failed = 0;
    int p0, remaining;

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);

    fifo_stream_reader #(.D_WIDTH(8), .PKT_LEN(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_r_en(fifo_r_en), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .rd_count(rd_count), .busy(busy)
    );

    // Single-word packets and a 4-bit counter, driven identically, to cover m_last and wrap corners.
    fifo_stream_reader #(.D_WIDTH(8), .PKT_LEN(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_r_en(u1_fifo_r_en), .m_valid(u1_m_valid),
        .m_data(u1_m_data), .m_last(u1_m_last), .m_ready(m_ready),
        .rd_count(u1_rd_count), .busy(u1_busy)
    );

    always @(posedge clk) begin
        if (fifo_r_en) begin
            fifo_data <= mem[rp[7:0]];
            rp        <= rp + 1;
            rd_issued <= rd_issued + 1;
        end
        if (rst) rd_issued <= 0;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wp[7:0]] = v;
        wp++;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_pops(input string tag, input int target, input int budget);
        int n = 0;
        while (popped < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(popped >= target), 1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            popped    = 0;
            exp_idx   = rp;
            tb_pk     = 0;
            last_cnt  = 0;
            hold_prev = 1'b0;
        end else begin
            check("no_empty_rd", 32'(fifo_r_en & fifo_empty), 0);
            check("outstanding", 32'((rd_issued - popped) <= 2), 1);
            if (u1_m_valid) check("u1_last", 32'(u1_m_last), 1);
            if (hold_prev) begin
                check("hold_valid", 32'(m_valid), 1);
                check("hold_data", 32'(m_data), 32'(prev_data));
                check("hold_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                check("data", 32'(m_data), 32'(mem[exp_idx[7:0]]));
                check("last", 32'(m_last), 32'(tb_pk == 3));
                $display("[TB] pop %0d data=%02h last=%0b", popped, m_data, m_last);
                if (tb_pk == 3) last_cnt++;
                tb_pk = (tb_pk + 1) % 4;
                exp_idx++;
                popped++;
            end
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end
    end

    initial begin
        // Reset held with a non-empty FIFO
        push(8'hA5);
        repeat (3) begin
            @(negedge clk);
            check("rst_r_en", 32'(fifo_r_en), 0);
            check("rst_valid", 32'(m_valid), 0);
            check("rst_count", 32'(rd_count), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_data", 32'(m_data), 0);
            check("rst_last", 32'(m_last), 0);
        end

        // Single word latency
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); check("t2_r_en_N", 32'(fifo_r_en), 1);
        @(negedge clk); check("t2_r_en_N1", 32'(fifo_r_en), 0);
        check("t2_valid_N1", 32'(m_valid), 0);
        check("t2_busy_N1", 32'(busy), 1);
        @(negedge clk); check("t2_valid_N2", 32'(m_valid), 1);
        check("t2_data_N2", 32'(m_data), 32'h A5);
        check("t2_last_N2", 32'(m_last), 0);
        @(negedge clk); check("t2_valid_N3", 32'(m_valid), 0);
        check("t2_count", 32'(rd_count), 1);
        check("t2_busy", 32'(busy), 0);

        // Full-rate burst of 30 words
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 30; i++) push(8'(i * 37 + 11));
        repeat (2) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("t3_valid_run", 32'(m_valid), 1);
        end
        @(negedge clk); check("t3_valid_end", 32'(m_valid), 0);
        check("t3_count", 32'(rd_count), 30);
        check("t3_lasts", 32'(last_cnt), 7);
        check("t3_u1_wrap", 32'(u1_rd_count), 14);

        // Alternating backpressure
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 30; i++) push(8'(i * 11 + 200));
        begin
            int n = 0;
            while (popped < 30 && n < 300) begin
                @(posedge clk); #1 m_ready = ~m_ready;
                n++;
            end
        end
        check("t4_done", 32'(popped), 30);
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t4_count", 32'(rd_count), 30);
        check("t4_lasts", 32'(last_cnt), 7);
        check("t4_busy", 32'(busy), 0);

        // Enable dropped mid-stream
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) push(8'(i + 8'h40));
        wait_pops("t5_start", 5, 50);
        enable = 1'b0;
        p0 = popped;
        repeat (8) begin
            @(negedge clk);
            check("t5_r_en_off", 32'(fifo_r_en), 0);
        end
        @(posedge clk); #1;
        check("t5_drain", 32'((popped - p0) <= 2), 1);
        check("t5_busy", 32'(busy), 0);
        check("t5_valid", 32'(m_valid), 0);
        enable = 1'b1;
        wait_pops("t5_resume", 20, 100);
        repeat (3) @(posedge clk);
        #1 check("t5_count", 32'(rd_count), 20);

        // Reset pulsed while a word is presented
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) push(8'(i * 5 + 8'h80));
        wait_pops("t6_start", 5, 50);
        check("t6_valid_pre", 32'(m_valid), 1);
        rst = 1'b1;
        #1;
        check("t6_valid_clr", 32'(m_valid), 0);
        check("t6_count_clr", 32'(rd_count), 0);
        check("t6_busy_clr", 32'(busy), 0);
        check("t6_r_en_clr", 32'(fifo_r_en), 0);
        check("t6_data_clr", 32'(m_data), 0);
        repeat (2) @(posedge clk);
        #1;
        remaining = wp - rp;
        rst = 1'b0;
        wait_pops("t6_resume", remaining, 100);
        repeat (3) @(posedge clk);
        #1 check("t6_count", 32'(rd_count), 32'(remaining));
        check("t6_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
